// File: rtl/lsu_data_port.sv
// Wishbone-classic data-port master for the Titan load/store path.
// Issues one bus cycle per aligned request; reports misalignment, bus error and timeout with the faulting address.
module lsu_data_port #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   // pipeline side
   input  logic [ADDR_W-1:0] maddr_i,
   input  logic [31:0]       mdat_i,
   input  logic              mread,
   input  logic              mwrite,
   input  logic              mbyte,
   input  logic              mhw,
   input  logic              mword,
   input  logic              munsigned,
   output logic [31:0]       data_o,
   output logic              mem_stall,
   output logic              mem_done,
   output logic              misaligned,
   output logic              mem_bus_err,
   output logic              mem_timeout,
   output logic [ADDR_W-1:0] err_addr_o,
   // bus side
   input  logic [31:0]       ddat_i,
   input  logic              dack_i,
   input  logic              derr_i,
   output logic [ADDR_W-1:0] daddr_o,
   output logic [31:0]       ddat_o,
   output logic [3:0]        dsel_o,
   output logic              dcyc_o,
   output logic              dstb_o,
   output logic              dwe_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   size_t             size_d, size_q;
   logic [ADDR_W-1:0] addr_q;
   logic              uns_q;
   logic              load_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              req;
   logic [1:0]        off;
   logic              misalign_d;
   logic [3:0]        sel_d;
   logic [31:0]       wdat_d;
   logic [31:0]       rd_shift;
   logic [31:0]       rd_ext;
   logic              start_bus, start_mis, ack_hit, err_hit, to_hit;

   assign req       = mread | mwrite;
   assign mem_stall = req & ~mem_done;
   assign off       = maddr_i[1:0];

   // Size priority byte > hw > word; no size bit set means word.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      size_d = SZ_WORD;
      sel_d  = 4'b1111;
      wdat_d = mdat_i;
      if (mbyte) begin
         size_d = SZ_BYTE;
         sel_d  = 4'b0001 << off;
         wdat_d = {4{mdat_i[7:0]}};
      end else if (mhw) begin
         size_d = SZ_HALF;
         sel_d  = off[1] ? 4'b1100 : 4'b0011;
         wdat_d = {2{mdat_i[15:0]}};
      end
      misalign_d = ((size_d == SZ_HALF) && off[0]) ||
                   ((size_d == SZ_WORD) && (off != 2'b00));
   end

   // Load data uses the offset and size latched at issue, so a withdrawn request still completes correctly.
   always_comb begin
      rd_shift = ddat_i >> {addr_q[1:0], 3'b000};
      rd_ext   = rd_shift;
      case (size_q)
         SZ_BYTE: rd_ext = uns_q ? {24'b0, rd_shift[7:0]}
                                 : {{24{rd_shift[7]}}, rd_shift[7:0]};
         SZ_HALF: rd_ext = uns_q ? {16'b0, rd_shift[15:0]}
                                 : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: non-blocking assignment, so every register samples pre-edge values regardless of statement order.
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      start_bus = 1'b0;
      start_mis = 1'b0;
      ack_hit   = 1'b0;
      err_hit   = 1'b0;
      to_hit    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               state_d = misalign_d ? S_DONE : S_BUS;
               start_mis = misalign_d;
               start_bus = ~misalign_d;
            end
         end
         S_BUS: begin
            // Ack wins over a simultaneous error.
            if (dack_i) begin
               ack_hit = 1'b1;
               state_d = S_DONE;
            end else if (derr_i) begin
               err_hit = 1'b1;
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               to_hit  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: the asynchronous clear drops dcyc_o/dstb_o at once, even in the middle of a bus cycle.
      if (!rst) begin
         data_o      <= '0;
         mem_done    <= 1'b0;
         misaligned  <= 1'b0;
         mem_bus_err <= 1'b0;
         mem_timeout <= 1'b0;
         err_addr_o  <= '0;
         daddr_o     <= '0;
         ddat_o      <= '0;
         dsel_o      <= '0;
         dcyc_o      <= 1'b0;
         dstb_o      <= 1'b0;
         dwe_o       <= 1'b0;
         addr_q      <= '0;
         size_q      <= SZ_BYTE;
         uns_q       <= 1'b0;
         load_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         mem_done    <= 1'b0;
         misaligned  <= 1'b0;
         mem_bus_err <= 1'b0;
         mem_timeout <= 1'b0;

         if (start_mis) begin
            err_addr_o <= maddr_i;
            misaligned <= 1'b1;
            mem_done   <= 1'b1;
         end

         if (start_bus) begin
            dcyc_o  <= 1'b1;
            dstb_o  <= 1'b1;
            dwe_o   <= mwrite;
            daddr_o <= {maddr_i[ADDR_W-1:2], 2'b00};
            dsel_o  <= sel_d;
            ddat_o  <= wdat_d;
            addr_q  <= maddr_i;
            size_q  <= size_d;
            uns_q   <= munsigned;
            load_q  <= ~mwrite;
            cnt_q   <= '0;
         end

         if (state_q == S_BUS) cnt_q <= cnt_q + CNT_W'(1);

         if (ack_hit | err_hit | to_hit) begin
            dcyc_o   <= 1'b0;
            dstb_o   <= 1'b0;
            mem_done <= 1'b1;
         end

         if (ack_hit && load_q) data_o <= rd_ext;

         if (err_hit) begin
            err_addr_o  <= addr_q;
            mem_bus_err <= 1'b1;
         end

         if (to_hit) begin
            err_addr_o  <= addr_q;
            mem_timeout <= 1'b1;
         end
      end
   end

endmodule
